sva_stim_sequencer: RTL and testbench
=====================================

// Module: sva_stim_sequencer
// PURPOSE
//  Programmable stimulus sequencer for property-check benches. Drives the
//  antecedent signal (sig_a) of an implication property as a burst of pulses:
//  delay, then N repetitions of high/low. Also drives a checker-enable (chk_en)
//  that gates the assertion (disable iff (!chk_en)) to the active window.
//  Replaces hand-written #delay initial blocks with a clocked, reusable sequencer.
// PARAMETERS
//  CNT_W  8  width of delay/high/low duration counters (cycles)
//  REP_W  4  width of repetition count
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      launch a sequence (sampled in IDLE only)
//  abort      in   1      terminate active sequence
//  cfg_delay  in   CNT_W  cycles in DELAY before first pulse (0 = skip DELAY)
//  cfg_high   in   CNT_W  cycles sig_a high per pulse (0 treated as 1)
//  cfg_low    in   CNT_W  cycles sig_a low after each pulse (0 treated as 1)
//  cfg_reps   in   REP_W  number of pulses (0 = empty sequence)
//  sig_a      out  1      generated stimulus, high only in HIGH state
//  chk_en     out  1      checker enable, high in HIGH and LOW states
//  busy       out  1      high in any state other than IDLE
//  done       out  1      1-cycle pulse: sequence completed normally
//  aborted    out  1      1-cycle pulse: sequence terminated by abort
//  rep_cnt    out  REP_W  completed pulses in current/last sequence
// BEHAVIOUR
//  - Reset: state=IDLE; sig_a, chk_en, busy, done, aborted = 0; rep_cnt = 0.
//  - All outputs registered (Moore on state reg); no combinational in->out path.
//  - cfg_* captured into shadow regs on accepted start; later cfg changes ignored.
//  - States IDLE, DELAY, HIGH, LOW. Duration counter loaded with N-1 on entry,
//    state exits when counter==0, so each state lasts exactly N cycles.
//  - IDLE: start && !abort -> rep_cnt=0; reps==0: stay IDLE, done=1 next cycle;
//    delay==0: -> HIGH; else -> DELAY. start ignored while busy.
//  - DELAY: after cfg_delay cycles -> HIGH.
//  - HIGH: after max(cfg_high,1) cycles -> LOW.
//  - LOW: after max(cfg_low,1) cycles rep_cnt+1; if rep_cnt+1==reps -> IDLE
//    with done=1 on the IDLE entry cycle, else -> HIGH.
//  - Latency: start sampled at edge k -> first sig_a high at edge k+1+cfg_delay.
//  - abort in DELAY/HIGH/LOW: -> IDLE next edge, aborted=1 one cycle, done=0,
//    rep_cnt holds value reached. abort in IDLE: no effect, wins over start.
//  - abort in final LOW exit cycle: abort wins (aborted, no done).
//  - rep_cnt saturates never: bounded by cfg_reps <= 2^REP_W-1.
//  - rst_n low mid-sequence: all outputs 0 immediately (asynchronous), IDLE.
// TESTING
//  1. delay=2,high=3,low=2,reps=1, start@cyc0 -> sig_a=1 cyc3-5, chk_en cyc3-7,
//     done=1 cyc8, rep_cnt=1, busy cyc1-7.
//  2. delay=0,high=1,low=1,reps=3 -> sig_a 1,0,1,0,1,0 cyc1-6, done cyc7, rep_cnt=3.
//  3. reps=0, start@cyc0 -> done=1 cyc1, busy/sig_a/chk_en stay 0.
//  4. high=0,low=0 -> treated as 1: alternating sig_a; abort in 2nd HIGH ->
//     sig_a=0 next cycle, aborted=1 one cycle, no done, rep_cnt=1.
//  5. start pulsed while busy and cfg_high changed mid-run -> no restart,
//     pulse widths unchanged; start+abort together in IDLE -> stays IDLE.
//  6. rst_n low between clock edges during HIGH -> sig_a/chk_en/busy drop at once;
//     after release, new start runs a clean sequence; property a_p_chk never fails.

Source files
------------

// File: rtl/sva_stim_sequencer_if.sv
// rtl/sva_stim_sequencer_if.sv - control/config/stimulus bundle for sva_stim_sequencer
//
// Signals:
//   start, abort                  launch / terminate a sequence
//   cfg_delay, cfg_high, cfg_low  durations in cycles (CNT_W bits)
//   cfg_reps                      number of pulses (REP_W bits)
//   sig_a, chk_en, busy           generated stimulus, checker enable, activity
//   done, aborted                 one-cycle completion / termination pulses
//   rep_cnt                       completed pulses in current/last sequence
// Modports: master drives start/abort/cfg_*, slave (the sequencer) drives the rest.
interface sva_stim_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [REP_W-1:0] cfg_reps;
    logic             sig_a;
    logic             chk_en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [REP_W-1:0] rep_cnt;

    modport master (
        output start, abort, cfg_delay, cfg_high, cfg_low, cfg_reps,
        input  sig_a, chk_en, busy, done, aborted, rep_cnt
    );

    modport slave (
        input  start, abort, cfg_delay, cfg_high, cfg_low, cfg_reps,
        output sig_a, chk_en, busy, done, aborted, rep_cnt
    );
endinterface

// File: rtl/sva_stim_sequencer.sv
// rtl/sva_stim_sequencer.sv - clocked burst-pulse stimulus sequencer with checker enable
//
// Ports:
//   clk    in  clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of sva_stim_sequencer_if (start/abort/cfg_* in,
//          sig_a/chk_en/busy/done/aborted/rep_cnt out)
// Every output is a register computed from the next state, so there is no
// combinational path from any input to any output.
module sva_stim_sequencer #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sva_stim_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Shadow copies of the pulse widths, stored as N-1 with 0 promoted to 1.
    logic [CNT_W-1:0] high_m1_q, high_m1_d;
    logic [CNT_W-1:0] low_m1_q, low_m1_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             sig_a_q, chk_en_q, busy_q;

    logic [CNT_W-1:0] cfg_high_m1;
    logic [CNT_W-1:0] cfg_low_m1;
    logic [REP_W-1:0] rep_next;

    assign cfg_high_m1 = (bus.cfg_high == CNT_ZERO) ? CNT_ZERO : bus.cfg_high - CNT_ONE;
    assign cfg_low_m1  = (bus.cfg_low  == CNT_ZERO) ? CNT_ZERO : bus.cfg_low  - CNT_ONE;
    assign rep_next    = rep_cnt_q + REP_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        high_m1_d = high_m1_q;
        low_m1_d  = low_m1_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (state_q == S_IDLE) begin
            // abort in IDLE only suppresses a coincident start.
            if (bus.start && !bus.abort) begin
                high_m1_d = cfg_high_m1;
                low_m1_d  = cfg_low_m1;
                reps_d    = bus.cfg_reps;
                rep_cnt_d = '0;
                if (bus.cfg_reps == '0) begin
                    done_d = 1'b1;
                end else if (bus.cfg_delay == CNT_ZERO) begin
                    state_d = S_HIGH;
                    cnt_d   = cfg_high_m1;
                end else begin
                    state_d = S_DELAY;
                    cnt_d   = bus.cfg_delay - CNT_ONE;
                end
            end
        end else if (bus.abort) begin
            // Abort beats everything, including the final LOW exit.
            state_d   = S_IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            case (state_q)
                S_DELAY: begin
                    state_d = S_HIGH;
                    cnt_d   = high_m1_q;
                end
                S_HIGH: begin
                    state_d = S_LOW;
                    cnt_d   = low_m1_q;
                end
                S_LOW: begin
                    rep_cnt_d = rep_next;
                    if (rep_next == reps_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = high_m1_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            high_m1_q <= '0;
            low_m1_q  <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            sig_a_q   <= 1'b0;
            chk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_m1_q <= high_m1_d;
            low_m1_q  <= low_m1_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            sig_a_q   <= (state_d == S_HIGH);
            chk_en_q  <= (state_d == S_HIGH) || (state_d == S_LOW);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign bus.sig_a   = sig_a_q;
    assign bus.chk_en  = chk_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.rep_cnt = rep_cnt_q;
endmodule

// File: tb/tb_sva_stim_sequencer.sv
// tb/tb_sva_stim_sequencer.sv - directed self-checking bench for sva_stim_sequencer
module tb_sva_stim_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    sva_stim_sequencer_if #(.CNT_W(8), .REP_W(4)) bus ();

    sva_stim_sequencer #(.CNT_W(8), .REP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_p_chk: assert property (@(posedge clk) disable iff (!bus.chk_en) bus.sig_a |-> bus.busy)
        else begin
            fails++;
            $display("FAIL a_p_chk: sig_a=%0b busy=%0b required busy=1", bus.sig_a, bus.busy);
        end

    // Drive cfg with start for one sampling edge; returns #1 after that edge.
    task automatic launch(input logic [7:0] d, input logic [7:0] h,
                          input logic [7:0] l, input logic [3:0] r);
        @(negedge clk);
        bus.cfg_delay = d;
        bus.cfg_high  = h;
        bus.cfg_low   = l;
        bus.cfg_reps  = r;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] got;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.cfg_delay = 8'd0;
        bus.cfg_high = 8'd1;
        bus.cfg_low = 8'd1;
        bus.cfg_reps = 4'd1;
        #1;
        got = {bus.sig_a, bus.chk_en, bus.busy, bus.done, bus.aborted, bus.rep_cnt};
        checks++;
        if (got !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required %b", got, 9'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_busy: got %b required 0", bus.busy);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_delay_single;
        logic [3:0] got, exp;
        launch(8'd2, 8'd3, 8'd2, 4'd1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp = {(c >= 3 && c <= 5), (c >= 3 && c <= 7), (c >= 1 && c <= 7), (c == 8)};
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL delay_single cyc%0d {sig_a,chk_en,busy,done}: got %b required %b", c, got, exp);
            end
            if (c == 8) begin
                checks++;
                if (bus.rep_cnt !== 4'd1) begin
                    fails++;
                    $display("FAIL delay_single rep_cnt: got %0d required 1", bus.rep_cnt);
                end
            end
        end
    endtask

    task automatic test_multi_pulse;
        logic [3:0] got, exp;
        launch(8'd0, 8'd1, 8'd1, 4'd3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp = {(c == 1 || c == 3 || c == 5), (c >= 1 && c <= 6), (c >= 1 && c <= 6), (c == 7)};
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL multi_pulse cyc%0d {sig_a,chk_en,busy,done}: got %b required %b", c, got, exp);
            end
            if (c == 7) begin
                checks++;
                if (bus.rep_cnt !== 4'd3) begin
                    fails++;
                    $display("FAIL multi_pulse rep_cnt: got %0d required 3", bus.rep_cnt);
                end
            end
        end
    endtask

    task automatic test_zero_reps;
        logic [3:0] got, exp;
        launch(8'd0, 8'd3, 8'd3, 4'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            exp = {1'b0, 1'b0, 1'b0, (c == 1)};
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL zero_reps cyc%0d {sig_a,chk_en,busy,done}: got %b required %b", c, got, exp);
            end
        end
        checks++;
        if (bus.rep_cnt !== 4'd0) begin
            fails++;
            $display("FAIL zero_reps rep_cnt: got %0d required 0", bus.rep_cnt);
        end
    endtask

    task automatic test_abort;
        logic [4:0] got, exp;
        launch(8'd0, 8'd0, 8'd0, 4'd5);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp = {(c == 1 || c == 3), (c <= 3), (c <= 3), 1'b0, (c == 4)};
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done, bus.aborted};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL abort cyc%0d {sig_a,chk_en,busy,done,aborted}: got %b required %b", c, got, exp);
            end
            if (c == 4) begin
                checks++;
                if (bus.rep_cnt !== 4'd1) begin
                    fails++;
                    $display("FAIL abort rep_cnt: got %0d required 1", bus.rep_cnt);
                end
            end
            bus.abort = (c == 3);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] got, exp;
        launch(8'd1, 8'd2, 8'd1, 4'd2);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp = {(c == 2 || c == 3 || c == 5 || c == 6), (c >= 2 && c <= 7), (c >= 1 && c <= 7), (c == 8)};
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL busy_restart cyc%0d {sig_a,chk_en,busy,done}: got %b required %b", c, got, exp);
            end
            if (c == 2) begin
                bus.start    = 1'b1;
                bus.cfg_high = 8'd5;
            end
            if (c == 3) bus.start = 1'b0;
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.cfg_delay = 8'd0;
        bus.cfg_reps = 4'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            got = {bus.sig_a, bus.chk_en, bus.busy, bus.done | bus.aborted};
            checks++;
            if (got !== 4'b0000) begin
                fails++;
                $display("FAIL start_abort_idle cyc%0d: got %b required 0000", c, got);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [2:0] got;
        logic [3:0] g4, exp;
        launch(8'd0, 8'd4, 8'd1, 4'd1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.sig_a !== 1'b1) begin
            fails++;
            $display("FAIL async_pre sig_a: got %b required 1", bus.sig_a);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.sig_a, bus.chk_en, bus.busy};
        checks++;
        if (got !== 3'b000) begin
            fails++;
            $display("FAIL async_reset {sig_a,chk_en,busy}: got %b required 000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd0, 8'd2, 8'd1, 4'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp = {(c <= 2), (c <= 3), (c <= 3), (c == 4)};
            g4 = {bus.sig_a, bus.chk_en, bus.busy, bus.done};
            checks++;
            if (g4 !== exp) begin
                fails++;
                $display("FAIL post_reset cyc%0d {sig_a,chk_en,busy,done}: got %b required %b", c, g4, exp);
            end
            if (c == 4) begin
                checks++;
                if (bus.rep_cnt !== 4'd1) begin
                    fails++;
                    $display("FAIL post_reset rep_cnt: got %0d required 1", bus.rep_cnt);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_delay_single();
        test_multi_pulse();
        test_zero_reps();
        test_abort();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
